switch_event_generator: RTL and testbench
=========================================

Name: switch_event_generator

Overview:
Per-button front end that converts one raw, bouncing push-button input into clean single-cycle events for the counter/display logic downstream. It contains a synchronizer, a debouncer, edge detection, and a hold-to-auto-repeat state machine. Its main output, o_step, is a one-cycle pulse that tells the downstream counter to advance. One instance is used per switch (reset, increment and decrement).

Parameters:
DEBOUNCE_LIMIT, 250000, consecutive stable cycles required before the debounced level changes (10 ms at 25 MHz)
HOLD_DELAY, 12500000, cycles from the o_press pulse to the first auto-repeat (500 ms)
REPEAT_PERIOD, 2500000, cycles between auto-repeat pulses after the first (100 ms)
CNT_W, 24, width of the internal counters; must hold max(DEBOUNCE_LIMIT, HOLD_DELAY, REPEAT_PERIOD)

Ports:
i_clk  in  1  system clock; all logic is on its rising edge
i_rst  in  1  synchronous, active-high reset
i_sw  in  1  raw switch level, asynchronous to i_clk, 1 = pressed
o_sw  out  1  debounced switch level
o_press  out  1  one-cycle pulse on debounced rising edge
o_release  out  1  one-cycle pulse on debounced falling edge
o_repeat  out  1  one-cycle pulse on each auto-repeat tick while held
o_step  out  1  one-cycle pulse meaning "advance once"; this is the signal the downstream counter consumes

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous, active-high.
- Reset values:
  - All outputs are 0.
  - Synchronizer flops, debounce counter and hold counter are 0.
  - FSM state is IDLE.
- Synchronizer:
  - Two flops on i_sw produce sw_sync.
  - No other logic may sample i_sw directly.
- Debouncer:
  - deb_cnt increments on every cycle where sw_sync != o_sw.
  - deb_cnt clears to 0 on any cycle where sw_sync == o_sw.
  - When deb_cnt == DEBOUNCE_LIMIT-1 and sw_sync still differs, o_sw takes the value of sw_sync on that edge and deb_cnt clears.
  - Latency from a clean i_sw step to the o_sw change is DEBOUNCE_LIMIT+2 cycles.
  - A glitch shorter than DEBOUNCE_LIMIT synchronized cycles produces no o_sw change.
- Edge detection:
  - o_sw_d is o_sw registered.
  - rise = o_sw & ~o_sw_d; fall = ~o_sw & o_sw_d.
  - o_press = rise and o_release = fall. Both are registered outputs, valid one cycle after the o_sw change.
- FSM (states IDLE, HELD, REPEAT; hold_cnt is CNT_W bits):
  - IDLE:
    - On rise: go to HELD and set hold_cnt to 0.
    - o_step stays 0; the press edge alone does not step.
  - HELD:
    - hold_cnt increments every cycle.
    - On fall: pulse o_step and go to IDLE. A short tap therefore steps once, on release.
    - Else, when hold_cnt == HOLD_DELAY-1: pulse o_repeat and o_step, clear hold_cnt, go to REPEAT.
  - REPEAT:
    - hold_cnt increments every cycle.
    - On fall: go to IDLE with no o_step. The release after repeats does not add an extra step.
    - Else, when hold_cnt == REPEAT_PERIOD-1: pulse o_repeat and o_step, clear hold_cnt.
- Timing:
  - The first o_repeat comes exactly HOLD_DELAY cycles after the o_press cycle.
  - Subsequent o_repeat pulses come every REPEAT_PERIOD cycles.
- Simultaneous fall and terminal count:
  - The fall wins.
  - In HELD this gives exactly one o_step (from the release) and no o_repeat.
  - In REPEAT this gives no pulse.
- Pulse width: o_step, o_press, o_release and o_repeat are each high for exactly one cycle and are never asserted on consecutive cycles.
- Reset mid-operation:
  - All state clears immediately, including during a hold.
  - If the switch is still pressed after reset, it is re-debounced from o_sw = 0. The result is a fresh o_press, with no o_step until release or repeat.
- Counters never wrap: each one is cleared at its terminal value.

Test Plan (use DEBOUNCE_LIMIT=4, HOLD_DELAY=20, REPEAT_PERIOD=8):
- Apply i_rst for 2 cycles with i_sw=1 → all outputs 0 during reset; after release of i_rst, o_sw rises 6 cycles later, o_press fires 1 cycle after that, and o_step stays 0.
- Bounce: i_sw toggles 1,0,1,0 each for 2 cycles, then stays 0 → o_sw stays 0 and there are no pulses.
- Tap: i_sw=1 for 10 cycles then 0 → one o_press, one o_release, and exactly one o_step on the o_release cycle; o_repeat never fires.
- Hold: release 50 cycles after o_press → o_repeat/o_step at press+20, +28, +36 and +44 (4 steps); o_release follows with no extra o_step.
- Collision: o_sw falls in the same cycle hold_cnt reaches 19 in HELD → exactly one o_step and no o_repeat; the FSM returns to IDLE.
- Mid-hold reset: assert i_rst at press+25 (REPEAT) while i_sw stays 1 → outputs 0 next cycle; then re-debounce, a new o_press 7 cycles after reset deasserts, and the first repeat 20 cycles later.

Source files
------------

// File: rtl/switch_event_generator.sv
// Push-button front end: synchronizer, debouncer, edge detect and hold-to-repeat
// FSM producing single-cycle step pulses for a downstream counter.
module switch_event_generator #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_DELAY     = 12500000,
  parameter int REPEAT_PERIOD  = 2500000,
  parameter int CNT_W          = 24
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_sw,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_step
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  logic             sync_a;
  logic             sw_sync;
  logic [CNT_W-1:0] deb_cnt;
  logic             sw_delayed;
  logic             rise;
  logic             fall;
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] next_hold_cnt;
  logic             step_next;
  logic             repeat_next;

  // Only the first synchronizer flop ever sees the raw asynchronous input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_a  <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sync_a  <= i_sw;
      sw_sync <= sync_a;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sw    <= 1'b0;
      deb_cnt <= '0;
    end else if (sw_sync != o_sw) begin
      if (deb_cnt == DEB_LAST) begin
        o_sw    <= sw_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign rise = o_sw & ~sw_delayed;
  assign fall = ~o_sw & sw_delayed;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_delayed <= 1'b0;
      o_press    <= 1'b0;
      o_release  <= 1'b0;
    end else begin
      sw_delayed <= o_sw;
      o_press    <= rise;
      o_release  <= fall;
    end
  end

  // Step and repeat are registered so they line up with o_press/o_release.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      o_step   <= 1'b0;
      o_repeat <= 1'b0;
    end else begin
      state    <= next_state;
      hold_cnt <= next_hold_cnt;
      o_step   <= step_next;
      o_repeat <= repeat_next;
    end
  end

  always_comb begin
    next_state    = state;
    next_hold_cnt = hold_cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          next_state    = HELD;
          next_hold_cnt = '0;
        end
      end
      HELD: begin
        next_hold_cnt = hold_cnt + CNT_W'(1);
        if (fall) begin
          next_state = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          next_state    = REPEAT;
          next_hold_cnt = '0;
        end
      end
      REPEAT: begin
        next_hold_cnt = hold_cnt + CNT_W'(1);
        if (fall) begin
          next_state = IDLE;
        end else if (hold_cnt == REP_LAST) begin
          next_hold_cnt = '0;
        end
      end
      default: begin
        next_state    = IDLE;
        next_hold_cnt = '0;
      end
    endcase
  end

  // A release wins over a coinciding terminal count.
  always_comb begin
    step_next   = 1'b0;
    repeat_next = 1'b0;
    case (state)
      HELD: begin
        if (fall) begin
          step_next = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          step_next   = 1'b1;
          repeat_next = 1'b1;
        end
      end
      REPEAT: begin
        if (!fall && hold_cnt == REP_LAST) begin
          step_next   = 1'b1;
          repeat_next = 1'b1;
        end
      end
      default: begin
        step_next   = 1'b0;
        repeat_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_switch_event_generator.sv
// Directed bench for switch_event_generator with short debounce/hold/repeat
// timings; pulse cycles are logged and compared against hand-derived offsets.
module tb_switch_event_generator;

  logic clk = 1'b0;
  logic rst;
  logic sw;
  logic o_sw;
  logic o_press;
  logic o_release;
  logic o_repeat;
  logic o_step;

  int cyc = 0;
  int n_press = 0;
  int n_release = 0;
  int n_repeat = 0;
  int n_step = 0;
  int press_cyc = -1;
  int release_cyc = -1;
  int step_cyc = -1;
  int rise_cyc = -1;
  int rep_cyc [0:63];
  logic sw_prev = 1'b0;

  int errors = 0;
  int checks = 0;

  switch_event_generator #(
    .DEBOUNCE_LIMIT(4),
    .HOLD_DELAY(20),
    .REPEAT_PERIOD(8),
    .CNT_W(24)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_sw(sw),
    .o_sw(o_sw),
    .o_press(o_press),
    .o_release(o_release),
    .o_repeat(o_repeat),
    .o_step(o_step)
  );

  always #5 clk = ~clk;

  // Log every pulse with the index of the rising edge that produced it.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (o_press === 1'b1) begin
      n_press = n_press + 1;
      press_cyc = cyc;
    end
    if (o_release === 1'b1) begin
      n_release = n_release + 1;
      release_cyc = cyc;
    end
    if (o_repeat === 1'b1) begin
      if (n_repeat < 64) rep_cyc[n_repeat] = cyc;
      n_repeat = n_repeat + 1;
    end
    if (o_step === 1'b1) begin
      n_step = n_step + 1;
      step_cyc = cyc;
    end
    if (o_sw === 1'b1 && sw_prev == 1'b0) rise_cyc = cyc;
    sw_prev = (o_sw === 1'b1);
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic sw_v);
    rst = rst_v;
    sw = sw_v;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitPress(input string tag, input int base);
    for (int i = 0; i < 60 && n_press == base; i++) @(negedge clk);
    checkOutput(tag, n_press - base, 1);
  endtask

  function automatic int repeatAt(input int idx);
    if (idx < 0 || idx > 63) return -1;
    return rep_cyc[idx];
  endfunction

  int r;
  int p;
  int bp;
  int br;
  int bs;
  int brep;

  initial begin
    for (int i = 0; i < 64; i++) rep_cyc[i] = -1;

    // Reset held for two edges with the button already pressed.
    applyStimulus(1'b1, 1'b1);
    waitCycles(2);
    checkOutput("reset outputs", int'({o_sw, o_press, o_release, o_repeat, o_step}), 0);
    r = cyc; bp = n_press; bs = n_step; brep = n_repeat;
    applyStimulus(1'b0, 1'b1);
    waitPress("startup press seen", bp);
    checkOutput("startup o_sw rise offset", rise_cyc - r, 6);
    checkOutput("startup press offset", press_cyc - r, 7);
    waitUntil(press_cyc + 3);
    checkOutput("no step on press", n_step - bs, 0);
    applyStimulus(1'b0, 1'b0);
    waitCycles(15);
    checkOutput("startup release step", n_step - bs, 1);
    checkOutput("startup no repeat", n_repeat - brep, 0);

    // Bounce shorter than the debounce window.
    bp = n_press; br = n_release; bs = n_step;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
      waitCycles(2);
    end
    applyStimulus(1'b0, 1'b0);
    waitCycles(20);
    checkOutput("bounce o_sw", int'(o_sw), 0);
    checkOutput("bounce press", n_press - bp, 0);
    checkOutput("bounce release", n_release - br, 0);
    checkOutput("bounce step", n_step - bs, 0);

    // Short tap steps once, on release.
    bp = n_press; br = n_release; bs = n_step; brep = n_repeat;
    applyStimulus(1'b0, 1'b1);
    waitCycles(10);
    applyStimulus(1'b0, 1'b0);
    waitCycles(20);
    checkOutput("tap press", n_press - bp, 1);
    checkOutput("tap release", n_release - br, 1);
    checkOutput("tap step", n_step - bs, 1);
    checkOutput("tap step on release", step_cyc - release_cyc, 0);
    checkOutput("tap width", release_cyc - press_cyc, 10);
    checkOutput("tap repeat", n_repeat - brep, 0);

    // Hold through four repeats; o_release lands at press+50.
    bp = n_press; bs = n_step; brep = n_repeat;
    applyStimulus(1'b0, 1'b1);
    waitPress("hold press seen", bp);
    p = press_cyc;
    waitUntil(p + 43);
    applyStimulus(1'b0, 1'b0);
    waitUntil(p + 60);
    checkOutput("hold repeat count", n_repeat - brep, 4);
    for (int i = 0; i < 4; i++)
      checkOutput("hold repeat offset", repeatAt(brep + i) - p, 20 + 8 * i);
    checkOutput("hold step count", n_step - bs, 4);
    checkOutput("hold release offset", release_cyc - p, 50);
    checkOutput("hold last step offset", step_cyc - p, 44);

    // Release collides with the HELD terminal count.
    bs = n_step; brep = n_repeat;
    bp = n_press;
    applyStimulus(1'b0, 1'b1);
    waitPress("collision press seen", bp);
    p = press_cyc;
    waitUntil(p + 13);
    applyStimulus(1'b0, 1'b0);
    waitUntil(p + 45);
    checkOutput("collision step count", n_step - bs, 1);
    checkOutput("collision repeat count", n_repeat - brep, 0);
    checkOutput("collision release offset", release_cyc - p, 20);
    checkOutput("collision step offset", step_cyc - p, 20);

    // Reset during REPEAT with the button still held.
    bp = n_press; brep = n_repeat;
    applyStimulus(1'b0, 1'b1);
    waitPress("midreset press seen", bp);
    p = press_cyc;
    waitUntil(p + 24);
    applyStimulus(1'b1, 1'b1);
    waitCycles(1);
    checkOutput("midreset outputs", int'({o_sw, o_press, o_release, o_repeat, o_step}), 0);
    checkOutput("midreset prior repeat", n_repeat - brep, 1);
    r = cyc; bp = n_press; bs = n_step;
    applyStimulus(1'b0, 1'b1);
    waitPress("repress seen", bp);
    p = press_cyc;
    checkOutput("repress offset", p - r, 7);
    waitUntil(p + 19);
    checkOutput("repress no early step", n_step - bs, 0);
    waitUntil(p + 20);
    checkOutput("repress first step", n_step - bs, 1);
    checkOutput("repress first repeat offset", repeatAt(n_repeat - 1) - p, 20);
    applyStimulus(1'b0, 1'b0);
    waitCycles(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
